fcvt_wb_stage: RTL and testbench

Registered result stage downstream of the combinational bfloat16-to-int32 converter in the FPU. It accepts the converter's sign-magnitude integer and 3-bit exception flag under a valid/ready handshake and converts the result to two's complement with saturation. Results are buffered in a 2-entry FIFO for the integer writeback port. It also keeps sticky exception flags and saturating event counters for the FPU CSR logic.

---
 rtl/fpu_pkg.sv | 36 +++
 rtl/fcvt_fifo2.sv | 66 ++++++
 rtl/fcvt_wb_stage.sv | 108 ++++++++++
 tb/tb_fcvt_wb_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: flag bit positions, integer constants, the buffered
// result record and the sign-magnitude to two's-complement conversion.
package fpu_pkg;

    localparam int FLAG_OVF  = 0;
    localparam int FLAG_UDF  = 1;
    // Upper bound on the destination tag width that a result record can carry.
    localparam int TAG_MAX_W = 16;

    localparam logic [31:0] INT_SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_ZERO    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]          data;
        logic [TAG_MAX_W-1:0] tag;
        logic [2:0]           flag;
    } cvt_res_t;

    // Overflow saturates even when underflow is also flagged; -0 folds to 0.
    function automatic logic [31:0] cvt_to_int(input logic [31:0] sm, input logic [2:0] flag);
        logic [31:0] mag;
        logic [31:0] res;
        mag = {1'b0, sm[30:0]};
        if (flag[FLAG_OVF]) begin
            res = INT_SAT_POS;
        end else if (flag[FLAG_UDF]) begin
            res = INT_ZERO;
        end else if (sm[31]) begin
            res = 32'd0 - mag;
        end else begin
            res = mag;
        end
        return res;
    endfunction

endpackage

// File: rtl/fcvt_fifo2.sv
// Two-entry FIFO of conversion results with registered count, full and empty.
module fcvt_fifo2
    import fpu_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  cvt_res_t push_data_i,
    input  logic     pop_i,
    output cvt_res_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    cvt_res_t   mem0_q, mem1_q;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       full_q, full_d;
    logic       empty_q, empty_d;

    // Pointer and occupancy next-state; push and pop together keep the count.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = push_i ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop_i  ? ~rd_ptr_q : rd_ptr_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == 2'd2);
        empty_d = (count_d == 2'd0);
    end

    // Storage, pointers and status flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_i && !wr_ptr_q) begin
                mem0_q <= push_data_i;
            end else if (push_i && wr_ptr_q) begin
                mem1_q <= push_data_i;
            end else begin
                mem0_q <= mem0_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head_o  = rd_ptr_q ? mem1_q : mem0_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/fcvt_wb_stage.sv
// Writeback stage for the bfloat16-to-int32 converter: converts to two's
// complement, buffers two results and keeps sticky flags and event counters.
module fcvt_wb_stage
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cvt_valid_i,
    output logic             cvt_ready_o,
    input  logic [31:0]      cvt_int_i,
    input  logic [2:0]       cvt_flag_i,
    input  logic [TAG_W-1:0] cvt_tag_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [31:0]      wb_data_o,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic [2:0]       wb_flag_o,
    output logic [1:0]       fflags_o,
    input  logic             fflags_clr_i,
    output logic [CNT_W-1:0] ovf_cnt_o,
    output logic [CNT_W-1:0] udf_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    cvt_res_t         res_s, head_s;
    logic             full_s, empty_s;
    logic             in_xfer_s, out_xfer_s;
    logic             tag_unused_s;
    logic [1:0]       fflags_q, fflags_d, fflags_base_s;
    logic [CNT_W-1:0] ovf_q, ovf_d, ovf_base_s;
    logic [CNT_W-1:0] udf_q, udf_d, udf_base_s;

    assign in_xfer_s  = cvt_valid_i & ~full_s;
    assign out_xfer_s = ~empty_s & wb_ready_i;

    // Build the converted record written into the FIFO.
    always_comb begin
        res_s                 = '0;
        res_s.data            = cvt_to_int(cvt_int_i, cvt_flag_i);
        res_s.tag[TAG_W-1:0]  = cvt_tag_i;
        res_s.flag            = cvt_flag_i;
    end

    fcvt_fifo2 u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (in_xfer_s),
        .push_data_i (res_s),
        .pop_i       (out_xfer_s),
        .head_o      (head_s),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

    // Clear applies first, so a simultaneous event lands on a zeroed state.
    always_comb begin
        fflags_base_s = fflags_clr_i ? 2'b00 : fflags_q;
        ovf_base_s    = fflags_clr_i ? '0 : ovf_q;
        udf_base_s    = fflags_clr_i ? '0 : udf_q;
        fflags_d      = fflags_base_s;
        ovf_d         = ovf_base_s;
        udf_d         = udf_base_s;
        if (in_xfer_s) begin
            fflags_d = fflags_base_s | {cvt_flag_i[FLAG_UDF], cvt_flag_i[FLAG_OVF]};
            if (cvt_flag_i[FLAG_OVF] && (ovf_base_s != CNT_MAX)) begin
                ovf_d = ovf_base_s + CNT_ONE;
            end else begin
                ovf_d = ovf_base_s;
            end
            if (cvt_flag_i[FLAG_UDF] && (udf_base_s != CNT_MAX)) begin
                udf_d = udf_base_s + CNT_ONE;
            end else begin
                udf_d = udf_base_s;
            end
        end else begin
            fflags_d = fflags_base_s;
        end
    end

    // Sticky flags and saturating counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fflags_q <= 2'b00;
            ovf_q    <= '0;
            udf_q    <= '0;
        end else begin
            fflags_q <= fflags_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign tag_unused_s = ^head_s.tag;
    assign cvt_ready_o  = ~full_s;
    assign wb_valid_o   = ~empty_s;
    assign wb_data_o    = head_s.data;
    assign wb_tag_o     = head_s.tag[TAG_W-1:0];
    assign wb_flag_o    = head_s.flag;
    assign fflags_o     = fflags_q;
    assign ovf_cnt_o    = ovf_q;
    assign udf_cnt_o    = udf_q;

endmodule

// File: tb/tb_fcvt_wb_stage.sv
// Directed self-checking bench for fcvt_wb_stage.
module tb_fcvt_wb_stage;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cvt_valid_i;
    logic        cvt_ready_o;
    logic [31:0] cvt_int_i;
    logic [2:0]  cvt_flag_i;
    logic [4:0]  cvt_tag_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_tag_o;
    logic [2:0]  wb_flag_o;
    logic [1:0]  fflags_o;
    logic        fflags_clr_i;
    logic [7:0]  ovf_cnt_o;
    logic [7:0]  udf_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fcvt_wb_stage #(.TAG_W(5), .CNT_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .cvt_valid_i(cvt_valid_i), .cvt_ready_o(cvt_ready_o),
        .cvt_int_i(cvt_int_i), .cvt_flag_i(cvt_flag_i), .cvt_tag_i(cvt_tag_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
        .wb_tag_o(wb_tag_o), .wb_flag_o(wb_flag_o), .fflags_o(fflags_o),
        .fflags_clr_i(fflags_clr_i), .ovf_cnt_o(ovf_cnt_o), .udf_cnt_o(udf_cnt_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] d, input logic [2:0] f, input logic [4:0] t);
        cvt_valid_i = 1'b1;
        cvt_int_i   = d;
        cvt_flag_i  = f;
        cvt_tag_i   = t;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; cvt_valid_i = 1'b0; cvt_int_i = 32'h0; cvt_flag_i = 3'b000;
        cvt_tag_i = 5'd0; wb_ready_i = 1'b0; fflags_clr_i = 1'b0;
        step(); step();
        rst_ni = 1'b1;
        step();
        n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got %0b want 0", wb_valid_o); end
        n_checks++; if (cvt_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", cvt_ready_o); end
        n_checks++; if (wb_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", wb_data_o); end
        n_checks++; if (wb_tag_o !== 5'd0 || wb_flag_o !== 3'd0) begin n_fail++; $display("FAIL reset_tag_flag got %0d/%0d want 0/0", wb_tag_o, wb_flag_o); end
        n_checks++; if (fflags_o !== 2'b00 || ovf_cnt_o !== 8'd0 || udf_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset_csr got %b/%0d/%0d want 0/0/0", fflags_o, ovf_cnt_o, udf_cnt_o); end
    endtask

    task automatic test_negative();
        wb_ready_i = 1'b1;
        offer(32'h8000_0005, 3'b000, 5'd3);
        step();
        cvt_valid_i = 1'b0;
        n_checks++; if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL neg_valid got %0b want 1", wb_valid_o); end
        n_checks++; if (wb_data_o !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL neg_data got %h want fffffffb", wb_data_o); end
        n_checks++; if (wb_tag_o !== 5'd3) begin n_fail++; $display("FAIL neg_tag got %0d want 3", wb_tag_o); end
        n_checks++; if (fflags_o !== 2'b00) begin n_fail++; $display("FAIL neg_fflags got %b want 00", fflags_o); end
        step();
        n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL neg_drain got %0b want 0", wb_valid_o); end
    endtask

    task automatic test_flags();
        wb_ready_i = 1'b1;
        offer(32'hFFFF_FFFF, 3'b001, 5'd1);
        step();
        n_checks++; if (wb_data_o !== 32'h7FFF_FFFF || wb_flag_o !== 3'b001) begin n_fail++; $display("FAIL ovf_data got %h/%b want 7fffffff/001", wb_data_o, wb_flag_o); end
        n_checks++; if (ovf_cnt_o !== 8'd1 || fflags_o !== 2'b01) begin n_fail++; $display("FAIL ovf_csr got %0d/%b want 1/01", ovf_cnt_o, fflags_o); end
        offer(32'h0000_0000, 3'b010, 5'd2);
        step();
        cvt_valid_i = 1'b0;
        n_checks++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h0 || wb_flag_o !== 3'b010 || wb_tag_o !== 5'd2) begin n_fail++; $display("FAIL udf_data got v%0b %h/%b/%0d want v1 0/010/2", wb_valid_o, wb_data_o, wb_flag_o, wb_tag_o); end
        n_checks++; if (fflags_o !== 2'b11 || ovf_cnt_o !== 8'd1 || udf_cnt_o !== 8'd1) begin n_fail++; $display("FAIL udf_csr got %b/%0d/%0d want 11/1/1", fflags_o, ovf_cnt_o, udf_cnt_o); end
        step();
    endtask

    task automatic test_conversions();
        logic [31:0] din [5] = '{32'h0000_0012, 32'h8000_0000, 32'h0000_0007, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [2:0]  fin [5] = '{3'b011, 3'b000, 3'b100, 3'b000, 3'b000};
        logic [31:0] dexp[5] = '{32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0007, 32'h7FFF_FFFF, 32'h8000_0001};
        fflags_clr_i = 1'b1;
        step();
        fflags_clr_i = 1'b0;
        n_checks++; if (fflags_o !== 2'b00 || ovf_cnt_o !== 8'd0 || udf_cnt_o !== 8'd0) begin n_fail++; $display("FAIL clr_csr got %b/%0d/%0d want 00/0/0", fflags_o, ovf_cnt_o, udf_cnt_o); end
        wb_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer(din[i], fin[i], 5'(i + 8));
            step();
            n_checks++;
            if (wb_valid_o !== 1'b1 || wb_data_o !== dexp[i] || wb_flag_o !== fin[i] || wb_tag_o !== 5'(i + 8)) begin
                n_fail++;
                $display("FAIL conv_%0d got v%0b %h/%b/%0d want v1 %h/%b/%0d", i, wb_valid_o, wb_data_o, wb_flag_o, wb_tag_o, dexp[i], fin[i], i + 8);
            end
        end
        cvt_valid_i = 1'b0;
        step();
        n_checks++; if (fflags_o !== 2'b11 || ovf_cnt_o !== 8'd1 || udf_cnt_o !== 8'd1) begin n_fail++; $display("FAIL conv_csr got %b/%0d/%0d want 11/1/1", fflags_o, ovf_cnt_o, udf_cnt_o); end
    endtask

    task automatic test_back_to_back();
        wb_ready_i = 1'b0;
        offer(32'h0000_0011, 3'b000, 5'd4);
        step();
        n_checks++; if (cvt_ready_o !== 1'b1 || wb_data_o !== 32'h11) begin n_fail++; $display("FAIL b2b_first got rdy%0b %h want rdy1 00000011", cvt_ready_o, wb_data_o); end
        offer(32'h8000_0001, 3'b000, 5'd5);
        step();
        offer(32'h7FFF_FFFF, 3'b000, 5'd6);
        n_checks++; if (cvt_ready_o !== 1'b0 || wb_valid_o !== 1'b1 || wb_data_o !== 32'h11) begin n_fail++; $display("FAIL b2b_full got rdy%0b v%0b %h want rdy0 v1 00000011", cvt_ready_o, wb_valid_o, wb_data_o); end
        step();
        n_checks++; if (cvt_ready_o !== 1'b0 || wb_tag_o !== 5'd4) begin n_fail++; $display("FAIL b2b_hold got rdy%0b tag%0d want rdy0 tag4", cvt_ready_o, wb_tag_o); end
        wb_ready_i = 1'b1;
        step();
        n_checks++; if (wb_data_o !== 32'hFFFF_FFFF || wb_tag_o !== 5'd5 || cvt_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_second got %h tag%0d rdy%0b want ffffffff tag5 rdy1", wb_data_o, wb_tag_o, cvt_ready_o); end
        step();
        cvt_valid_i = 1'b0;
        n_checks++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h7FFF_FFFF || wb_tag_o !== 5'd6) begin n_fail++; $display("FAIL b2b_third got v%0b %h tag%0d want v1 7fffffff tag6", wb_valid_o, wb_data_o, wb_tag_o); end
        step();
        n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0b want 0", wb_valid_o); end
    endtask

    task automatic test_saturate();
        fflags_clr_i = 1'b1;
        step();
        fflags_clr_i = 1'b0;
        wb_ready_i   = 1'b1;
        offer(32'h4000_0000, 3'b001, 5'd7);
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 254) begin
                n_checks++; if (ovf_cnt_o !== 8'd255) begin n_fail++; $display("FAIL sat_reach got %0d want 255", ovf_cnt_o); end
            end
        end
        n_checks++; if (ovf_cnt_o !== 8'd255 || udf_cnt_o !== 8'd0) begin n_fail++; $display("FAIL sat_hold got %0d/%0d want 255/0", ovf_cnt_o, udf_cnt_o); end
        fflags_clr_i = 1'b1;
        offer(32'h0000_0001, 3'b010, 5'd7);
        step();
        fflags_clr_i = 1'b0;
        cvt_valid_i  = 1'b0;
        n_checks++; if (fflags_o !== 2'b10 || ovf_cnt_o !== 8'd0 || udf_cnt_o !== 8'd1) begin n_fail++; $display("FAIL clr_and_push got %b/%0d/%0d want 10/0/1", fflags_o, ovf_cnt_o, udf_cnt_o); end
        step();
    endtask

    task automatic test_reset_mid();
        wb_ready_i = 1'b0;
        offer(32'h0000_0001, 3'b001, 5'd1);
        step();
        offer(32'h0000_0002, 3'b000, 5'd2);
        step();
        cvt_valid_i = 1'b0;
        n_checks++; if (cvt_ready_o !== 1'b0 || wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_fill got rdy%0b v%0b want rdy0 v1", cvt_ready_o, wb_valid_o); end
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        n_checks++; if (wb_valid_o !== 1'b0 || cvt_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_rst_hs got v%0b rdy%0b want v0 rdy1", wb_valid_o, cvt_ready_o); end
        n_checks++; if (fflags_o !== 2'b00 || ovf_cnt_o !== 8'd0 || udf_cnt_o !== 8'd0 || wb_data_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst_state got %b/%0d/%0d %h want 00/0/0 0", fflags_o, ovf_cnt_o, udf_cnt_o, wb_data_o); end
        wb_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_stale_%0d got v%0b want v0", i, wb_valid_o); end
        end
    endtask

    initial begin
        test_reset();
        test_negative();
        test_flags();
        test_conversions();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
